// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle shared by the NUM_REQ producers, the FIFO write pins and the arbiter.
// The arbiter takes the slave modport; producers/FIFO side take the master modport.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_din;
    logic [ID_W-1:0]           owner_id;
    logic                      busy;

    modport master (
        output req, req_data, fifo_full,
        input  gnt, fifo_wr_en, fifo_din, owner_id, busy
    );

    modport slave (
        input  req, req_data, fifo_full,
        output gnt, fifo_wr_en, fifo_din, owner_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write side of one synchronous FIFO.
// Optional STALL-cycle counter (stats_clr / stall_cycles) under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
    input logic              clk,
    input logic              rst_n,
    fifo_wr_arbiter_if.slave bus
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [15:0]      stall_cycles
`endif
);

    typedef enum logic [1:0] {StIdle, StBurst, StStall} state_e;

    localparam logic [3:0]      LastBeat = 4'(MAX_BURST - 1);
    localparam logic [ID_W-1:0] LastReq  = ID_W'(NUM_REQ - 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   rr_last_q, rr_last_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;

    logic              owner_req;
    logic [DATA_W-1:0] owner_data;
    logic              accept;
    logic [ID_W-1:0]   winner;
    logic              found;
    int unsigned       idx;

    // Owner mux over the packed request/data buses.
    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == ID_W'(i)) begin
                owner_req  = bus.req[i];
                owner_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Search starts just after the last owner so every requester gets its turn.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(rr_last_q) + k) % NUM_REQ;
            if (!found && bus.req[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign accept = (state_q == StBurst) && owner_req && !bus.fifo_full;

    always_comb begin
        bus.gnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.gnt[i] = accept && (owner_q == ID_W'(i));
        end
    end

    assign bus.fifo_wr_en = accept;
    assign bus.fifo_din   = (state_q == StIdle) ? '0 : owner_data;
    assign bus.owner_id   = owner_q;
    assign bus.busy       = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    owner_d     = winner;
                    burst_cnt_d = '0;
                    state_d     = StBurst;
                end
            end
            StBurst: begin
                if (!owner_req) begin
                    state_d   = StIdle;
                    rr_last_d = owner_q;
                end else if (bus.fifo_full) begin
                    state_d = StStall;
                end else begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (burst_cnt_q == LastBeat) begin
                        state_d   = StIdle;
                        rr_last_d = owner_q;
                    end
                end
            end
            StStall: begin
                if (!owner_req) begin
                    state_d   = StIdle;
                    rr_last_d = owner_q;
                end else if (!bus.fifo_full) begin
                    state_d = StBurst;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            rr_last_q   <= LastReq;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Clear wins over increment; the counter saturates instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stats_clr) begin
            stall_cnt_d = '0;
        end else if (state_q == StStall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that lets NUM_REQ producers share the write side of one 8-bit synchronous FIFO.
- Sits between the producers and the FIFO's wr_en/buf_in/buf_full pins.
- Grants bursts of up to MAX_BURST beats to one owner, then rotates to the next requester.
- Never asserts a write while the FIFO reports full.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 8, data width per requester; matches the FIFO word.
- MAX_BURST, 4, maximum accepted beats per ownership; legal range 1..15.
- ID_W, $clog2(NUM_REQ), owner index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester write request; level, held while data is valid.
- req_data  in  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot beat-accept strobe (combinational); the beat is consumed on the clock edge.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable (combinational).
- fifo_din  out  DATA_W  FIFO write data; equals the owner's req_data.
- owner_id  out  ID_W  registered index of the current or last owner.
- busy  out  1  high when state != IDLE.

Behaviour:
- Interface decided: one clock; reset is asynchronous and active-low.
  - Clock port is clk.
  - Reset port is rst_n.
- Reset values:
  - state IDLE.
  - owner_id 0.
  - rr_last = NUM_REQ-1, so requester 0 has first priority.
  - burst_cnt 0.
  - gnt 0, fifo_wr_en 0, busy 0.
  - fifo_din 0 (the owner mux output is forced to 0 in IDLE).
- States: IDLE, BURST, STALL.
- IDLE:
  - No grants are issued.
  - If req != 0, select the first set bit searching rr_last+1, rr_last+2, ... with modulo NUM_REQ wrap.
  - Register the winner into owner_id, clear burst_cnt, go to BURST.
  - Arbitration ignores fifo_full.
  - Latency from request to first beat is 1 cycle minimum.
- BURST:
  - accept = req[owner_id] && !fifo_full.
  - gnt[owner_id] = accept; fifo_wr_en = accept; fifo_din = req_data[owner_id].
  - On accept, burst_cnt is incremented.
  - Exit to IDLE, with rr_last <= owner_id, when either:
    - accept and burst_cnt == MAX_BURST-1, or
    - !req[owner_id] (owner withdrew; no beat that cycle).
  - If req[owner_id] && fifo_full, go to STALL.
- STALL:
  - gnt = 0, fifo_wr_en = 0, burst_cnt held.
  - When !fifo_full, go to BURST; the next beat is issued the cycle after.
  - If the owner drops req while in STALL, go to IDLE and update rr_last.
- Transition from IDLE always spends one arbitration cycle, so back-to-back owners have a 1-cycle gap.
- gnt is strictly one-hot or zero, and is never asserted while fifo_full == 1.
- Non-owner requests are ignored until the owner releases; no preemption.
- Requester i is granted within (NUM_REQ-1)*(MAX_BURST+1)+1 cycles of request, excluding full stalls.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronous). Any beat not yet clocked is lost; the FIFO is reset by the same network.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds output stall_cycles [15:0].
  - Counts cycles spent in STALL; saturates at 16'hFFFF.
  - Cleared by rst_n and by the synchronous input stats_clr (1 bit, priority over increment).
- Undefined:
  - Neither port exists; no counter logic is generated.
  - All other behaviour is identical.

Test Plan:
1. Reset, then req=4'b0001, req_data[7:0]=8'hA5..A8 each accepted beat, fifo_full=0 -> one idle cycle, then gnt=4'b0001 for 4 consecutive cycles with fifo_din A5,A6,A7,A8. Then IDLE for 1 cycle, then the next burst starts. owner_id=0 throughout.
2. req=4'b1111 held continuously, fifo_full=0 -> owners in order 0,1,2,3,0. Each burst is 4 beats, separated by 1 idle cycle; 20 writes in 25 cycles.
3. Owner 2 mid-burst after 2 beats, fifo_full raised for 3 cycles -> gnt=0 and fifo_wr_en=0 during full. STALL for 3 cycles, resume in BURST, complete the remaining 2 beats; stall_cycles=3 if STATS_EN.
4. Owner 1 drops req after 1 beat while req[3]=1 -> IDLE next cycle, then owner_id=3 (not 0). rr_last=1.
5. rst_n pulsed low for 1 cycle during beat 3 of a burst by owner 2 -> immediately gnt=0, fifo_wr_en=0, busy=0, owner_id=0. After release, with req=4'b0101, the next owner is 0.
6. fifo_full=1 held while req=4'b0010 -> IDLE to BURST to STALL. No write for 10 cycles. After fifo_full falls, the first write occurs 2 cycles later.
